// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file and its sweep controller.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam int ZERO_IDX = 0;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_sb_sweep_ctrl.sv
// Clear-sweep FSM: zeroes every entry once after reset and again on each accepted clear request.
module regfile_sb_sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int AW       = addr_w(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          sweep_we_o,
    output logic [AW-1:0] sweep_addr_o,
    output logic          pend_clr_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sweep_we_o = 1'b0;
        pend_clr_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d    = SWEEP;
                    ptr_d      = '0;
                    pend_clr_o = 1'b1;
                end
            end
            SWEEP: begin
                sweep_we_o = 1'b1;
                ptr_d      = ptr_q + AW'(1);
                if (ptr_q == AW'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    assign busy_o       = (state_q == SWEEP);
    assign sweep_addr_o = ptr_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard and hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     rsv_conflict,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    logic          busy, sweep_we, pend_clr;
    logic [AW-1:0] sweep_addr;

    regfile_sb_sweep_ctrl #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_sweep (
        .clk_i        (clk),
        .rst_ni       (rst),
        .clr_req_i    (clr_req),
        .busy_o       (busy),
        .sweep_we_o   (sweep_we),
        .sweep_addr_o (sweep_addr),
        .pend_clr_o   (pend_clr)
    );

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
    endfunction

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                conflict_q, conflict_d;
    logic                wr_ok, rsv_ok;

    // A clear request in IDLE takes priority and drops same-cycle writes/reserves.
    assign wr_ok  = wr_en  && !busy && !clr_req && in_range(wr_addr)  && !is_zero(wr_addr);
    assign rsv_ok = rsv_en && !busy && !clr_req && in_range(rsv_addr) && !is_zero(rsv_addr);

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        pend_d     = pend_q;
        conflict_d = 1'b0;
        if (pend_clr) begin
            pend_d = '0;
        end else begin
            if (wr_ok) pend_d[wr_addr] = 1'b0;
            // A register being released this cycle is not a conflict; the new reservation wins.
            if (rsv_ok) begin
                conflict_d       = pend_q[rsv_addr] && !(wr_ok && (wr_addr == rsv_addr));
                pend_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
        end
    end

    assign rsv_conflict = conflict_q;
    assign clr_busy     = busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              ready;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data  = '0;
            ready = 1'b0;
            if (!busy && in_range(addr)) begin
                if (is_zero(addr)) begin
                    ready = 1'b1;
`ifdef REGFILE_BYPASS_EN
                end else if (wr_ok && (wr_addr == addr)) begin
                    data  = wr_data;
                    ready = 1'b1;
`endif
                end else begin
                    data  = mem_q[addr];
                    ready = !pend_q[addr];
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_ready[k]                 = ready;
    end

endmodule
